// File: rtl/cpu_control_fsm.sv
// Multi-cycle CPU control unit: sequences fetch/decode/execute/memory/writeback,
// owns the program counter, retired-instruction count and the memory-timeout fault.
module cpu_control_fsm #(
  parameter logic [12:0] RESET_PC    = 13'h0000,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        memDone,
  input  logic [2:0]  opcode,
  input  logic        BEQ,
  input  logic [12:0] newPC,
  output logic        read,
  output logic        write,
  output logic        instruction,
  output logic        instructionType,
  output logic [2:0]  ALU_Op,
  output logic [12:0] PC,
  output logic        irLoad,
  output logic        regWrite,
  output logic        error,
  output logic [15:0] instr_count
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM_RD,
    S_MEM_WR,
    S_WRITEBACK,
    S_BRANCH,
    S_FAULT
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_LW   = 3'b101;
  localparam logic [2:0] OP_SW   = 3'b110;
  localparam logic [2:0] OP_BEQ  = 3'b111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  // The wait counter counts completed idle wait cycles; the last allowed one is LIMIT-1.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      state_q;
  state_t      state_d;
  logic [2:0]  op_q;
  logic [7:0]  wait_cnt_q;
  logic [12:0] pc_q;
  logic [15:0] instr_cnt_q;
  logic        error_q;

  logic        in_wait;
  logic        wait_expired;
  logic        retire;
  logic [12:0] pc_next;

  function automatic logic [2:0] alu_sel(input logic [2:0] op);
    case (op)
      OP_SUB, OP_BEQ: alu_sel = ALU_SUB;
      OP_AND:         alu_sel = ALU_AND;
      OP_OR:          alu_sel = ALU_OR;
      default:        alu_sel = ALU_ADD;
    endcase
  endfunction

  function automatic logic [12:0] pc_inc(input logic [12:0] pc);
    pc_inc = pc + 13'd1;
  endfunction

  always_comb begin
    state_d      = state_q;
    in_wait      = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    wait_expired = (wait_cnt_q == WAIT_LAST);
    case (state_q)
      S_IDLE:      if (run) state_d = S_FETCH;
      S_FETCH: begin
        if (memDone)           state_d = S_DECODE;
        else if (wait_expired) state_d = S_FAULT;
      end
      S_DECODE:    state_d = S_EXECUTE;
      S_EXECUTE: begin
        case (op_q)
          OP_LW:   state_d = S_MEM_RD;
          OP_SW:   state_d = S_MEM_WR;
          OP_BEQ:  state_d = S_BRANCH;
          default: state_d = S_WRITEBACK;
        endcase
      end
      S_MEM_RD: begin
        if (memDone)           state_d = S_WRITEBACK;
        else if (wait_expired) state_d = S_FAULT;
      end
      S_MEM_WR: begin
        if (memDone)           state_d = S_FETCH;
        else if (wait_expired) state_d = S_FAULT;
      end
      S_WRITEBACK: state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_FAULT:     state_d = S_FAULT;
      default:     state_d = S_IDLE;
    endcase
  end

  // An instruction retires on the cycle that hands control back to FETCH.
  always_comb begin
    retire  = (state_q == S_WRITEBACK) || (state_q == S_BRANCH) ||
              ((state_q == S_MEM_WR) && memDone);
    pc_next = ((state_q == S_BRANCH) && BEQ) ? newPC : pc_inc(pc_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= 3'b000;
      wait_cnt_q  <= 8'd0;
      pc_q        <= RESET_PC;
      instr_cnt_q <= 16'd0;
      error_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= opcode;
      // Staying in a wait state means memDone was low; any other move restarts the count.
      if (in_wait && !memDone && (state_d == state_q)) wait_cnt_q <= wait_cnt_q + 8'd1;
      else                                             wait_cnt_q <= 8'd0;
      if (retire) begin
        pc_q        <= pc_next;
        instr_cnt_q <= instr_cnt_q + 16'd1;
      end
      if (state_d == S_FAULT) error_q <= 1'b1;
    end
  end

  always_comb begin
    read            = 1'b0;
    write           = 1'b0;
    instruction     = 1'b0;
    instructionType = 1'b0;
    ALU_Op          = ALU_ADD;
    regWrite        = 1'b0;
    irLoad          = 1'b0;
    case (state_q)
      S_FETCH: begin
        read        = 1'b1;
        instruction = 1'b1;
        irLoad      = memDone;
      end
      S_EXECUTE: begin
        ALU_Op          = alu_sel(op_q);
        instructionType = op_q[2];
      end
      S_MEM_RD: begin
        read            = 1'b1;
        instructionType = op_q[2];
      end
      S_MEM_WR: begin
        write           = 1'b1;
        instructionType = op_q[2];
      end
      S_WRITEBACK: begin
        regWrite        = 1'b1;
        instructionType = op_q[2];
      end
      S_BRANCH: begin
        ALU_Op          = ALU_SUB;
        instructionType = 1'b1;
      end
      default: ;
    endcase
  end

  assign PC          = pc_q;
  assign error       = error_q;
  assign instr_count = instr_cnt_q;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Randomized scoreboard bench for cpu_control_fsm: a driver issues instructions and
// pushes their expected outcome; a monitor reconstructs each instruction from the strobes.
module tb_cpu_control_fsm;

  localparam logic [12:0] RESET_PC = 13'h0000;

  logic        clk, reset, run, memDone, BEQ;
  logic [2:0]  opcode;
  logic [12:0] newPC;
  logic        read, write, instruction, instructionType, irLoad, regWrite, error;
  logic [2:0]  ALU_Op;
  logic [12:0] PC;
  logic [15:0] instr_count;

  cpu_control_fsm #(.RESET_PC(RESET_PC), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .run(run), .memDone(memDone), .opcode(opcode),
    .BEQ(BEQ), .newPC(newPC), .read(read), .write(write), .instruction(instruction),
    .instructionType(instructionType), .ALU_Op(ALU_Op), .PC(PC), .irLoad(irLoad),
    .regWrite(regWrite), .error(error), .instr_count(instr_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct { int op; int fw; int mw; int alu; int pc; int cnt; int lat; } exp_t;
  typedef struct { string name; int act; int req; } dchk_t;

  exp_t  exp_q[$];
  dchk_t dq[$];
  int    checks = 0;
  int    errors = 0;
  int    m_pc;
  int    m_cnt;
  int    alu_tab [8] = '{0, 1, 2, 3, 0, 0, 0, 1};

  task automatic chk(input string n, input int a, input int r);
    checks++;
    if (a !== r) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", n, a, r);
    end
  endtask

  task automatic dpush(input string n, input int a, input int r);
    dchk_t d;
    d.name = n; d.act = a; d.req = r;
    dq.push_back(d);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fetch(output bit ok);
    int guard = 0;
    while (!(read && instruction) && guard < 20) begin
      tick();
      guard++;
    end
    ok = read && instruction;
    if (!ok) dpush("fetch_wait_bound", 0, 1);
  endtask

  // Issue one instruction starting from the FETCH state; fw/mw are wait cycles before memDone.
  task automatic run_instr(input int op, input int fw, input int mw, input bit beq, input int npc);
    exp_t e;
    bit ok;
    wait_fetch(ok);
    if (!ok) return;
    opcode = 3'(op);
    BEQ    = beq;
    newPC  = 13'(npc);
    e.op  = op; e.fw = fw; e.mw = mw; e.alu = alu_tab[op];
    e.pc  = (op == 7 && beq) ? npc : (m_pc + 1) % 8192;
    m_pc  = e.pc;
    m_cnt = (m_cnt + 1) % 65536;
    e.cnt = m_cnt;
    e.lat = fw + 3 + ((op == 5) ? mw + 2 : (op == 6) ? mw + 1 : 1);
    exp_q.push_back(e);
    memDone = 1'b0;
    repeat (fw) tick();
    memDone = 1'b1;
    tick();
    memDone = 1'($urandom_range(0, 1));
    tick();
    memDone = 1'($urandom_range(0, 1));
    tick();
    memDone = 1'b0;
    if (op == 5 || op == 6) begin
      repeat (mw) tick();
      memDone = 1'b1;
      tick();
      memDone = 1'b0;
    end
  endtask

  // Monitor: segments the strobe stream into instructions and retires them at the next fetch.
  initial begin : monitor
    int phase, fcyc, ild, lat, rdc, wrc, rwc, qc, dec_str, exe_alu, exe_it, exe_str, br_alu, br_it;
    exp_t  e;
    dchk_t d;
    phase = 0;
    forever begin
      @(negedge clk);
      while (dq.size() > 0) begin
        d = dq.pop_front();
        chk(d.name, d.act, d.req);
      end
      if (reset !== 1'b0) begin
        phase = 0;
        continue;
      end
      if ((phase == 0 || phase == 4) && read && instruction) begin
        if (phase == 4) begin
          if (exp_q.size() == 0) chk("unexpected_retire", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("fetch_cycles", fcyc, e.fw + 1);
            chk("irload_pulses", ild, 1);
            chk("decode_strobes", dec_str, 0);
            chk("execute_strobes", exe_str, 0);
            chk("execute_alu_op", exe_alu, e.alu);
            chk("execute_itype", exe_it, e.op / 4);
            chk("mem_rd_cycles", rdc, (e.op == 5) ? e.mw + 1 : 0);
            chk("mem_wr_cycles", wrc, (e.op == 6) ? e.mw + 1 : 0);
            chk("regwrite_pulses", rwc, (e.op == 6 || e.op == 7) ? 0 : 1);
            chk("quiet_cycles", qc, (e.op == 7) ? 1 : 0);
            if (e.op == 7) begin
              chk("branch_alu_op", br_alu, 1);
              chk("branch_itype", br_it, 1);
            end
            chk("latency", lat, e.lat);
            chk("pc", PC, e.pc);
            chk("instr_count", instr_count, e.cnt);
          end
        end
        fcyc = 1; ild = irLoad; lat = 1; rdc = 0; wrc = 0; rwc = 0; qc = 0;
        br_alu = 0; br_it = 0;
        phase = irLoad ? 2 : 1;
      end else begin
        case (phase)
          1: begin
            lat++;
            if (read && instruction) fcyc++;
            ild += irLoad;
            if (irLoad) phase = 2;
          end
          2: begin
            lat++;
            dec_str = read | write | regWrite | irLoad;
            phase = 3;
          end
          3: begin
            lat++;
            exe_alu = ALU_Op;
            exe_it  = instructionType;
            exe_str = read | write | regWrite | irLoad;
            phase = 4;
          end
          4: begin
            lat++;
            ild += irLoad;
            if (read && !instruction) rdc++;
            if (write) wrc++;
            if (regWrite) rwc++;
            if (!read && !write && !regWrite) begin
              qc++;
              br_alu = ALU_Op;
              br_it  = instructionType;
            end
          end
          default: ;
        endcase
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    bit ok;
    reset = 1'b1; run = 1'b0; memDone = 1'b0; opcode = 3'b000; BEQ = 1'b0; newPC = 13'h0;
    m_pc = RESET_PC; m_cnt = 0;
    repeat (3) tick();
    dpush("rst_read", read, 0);
    dpush("rst_write", write, 0);
    dpush("rst_instruction", instruction, 0);
    dpush("rst_regwrite", regWrite, 0);
    dpush("rst_irload", irLoad, 0);
    dpush("rst_alu_op", ALU_Op, 0);
    dpush("rst_pc", PC, RESET_PC);
    dpush("rst_error", error, 0);
    dpush("rst_instr_count", instr_count, 0);
    reset = 1'b0;
    memDone = 1'b1;
    repeat (2) tick();
    dpush("idle_no_run_read", read, 0);
    memDone = 1'b0;

    run = 1'b1;
    tick();
    run = 1'b0;
    dpush("first_fetch_read", read, 1);
    dpush("first_fetch_pc", PC, RESET_PC);

    run_instr(0, 0, 0, 0, 0);
    run_instr(5, 0, 3, 0, 0);
    run_instr(7, 0, 0, 1, 'h0A5);
    run_instr(7, 1, 0, 0, 'h123);
    run_instr(7, 0, 0, 1, 'h1FFF);
    run_instr(6, 3, 2, 0, 0);
    run_instr(5, 3, 3, 1, 'h77);
    run_instr(4, 2, 0, 0, 0);
    for (int i = 0; i < 40; i++)
      run_instr(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 8191)));

    // Starve the next fetch: the fault must land after exactly four wait cycles.
    wait_fetch(ok);
    memDone = 1'b0;
    repeat (3) tick();
    dpush("pre_timeout_read", read, 1);
    dpush("pre_timeout_error", error, 0);
    dpush("sb_drained", exp_q.size(), 0);
    tick();
    dpush("fault_error", error, 1);
    dpush("fault_read", read, 0);
    dpush("fault_irload", irLoad, 0);
    run = 1'b1;
    repeat (3) tick();
    dpush("fault_ignores_run", read, 0);
    dpush("fault_sticky", error, 1);
    run = 1'b0;

    reset = 1'b1;
    tick();
    reset = 1'b0;
    dpush("clr_error", error, 0);
    dpush("clr_pc", PC, RESET_PC);
    dpush("clr_instr_count", instr_count, 0);
    repeat (2) tick();
    dpush("clr_idle_read", read, 0);

    // Reset in the middle of a store that follows one completed instruction.
    m_pc = RESET_PC; m_cnt = 0;
    run = 1'b1;
    tick();
    run = 1'b0;
    run_instr(1, 0, 0, 0, 0);
    wait_fetch(ok);
    opcode = 3'b110;
    memDone = 1'b1;
    tick();
    memDone = 1'b0;
    repeat (2) tick();
    dpush("midwr_write", write, 1);
    dpush("midwr_count", instr_count, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    dpush("midwr_rst_write", write, 0);
    dpush("midwr_rst_read", read, 0);
    dpush("midwr_rst_count", instr_count, 0);
    dpush("midwr_rst_pc", PC, RESET_PC);
    for (int i = 0; i < 3; i++) begin
      dpush("midwr_irload", irLoad, 0);
      dpush("midwr_regwrite", regWrite, 0);
      tick();
    end
    dpush("midwr_idle_read", read, 0);

    for (int i = 0; i < 20 && dq.size() > 0; i++) @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_control_fsm.md
Name: cpu_control_fsm

Overview:
Multi-cycle control unit that sequences the CPU datapath through fetch, decode, execute, memory and writeback.
- Drives the datapath strobes: read, write, instruction, instructionType, ALU_Op and the 13-bit PC.
- Waits on the main-memory memDone handshake, and uses BEQ/newPC from the datapath to resolve branches.
- Sits directly above the datapath; one instance per CPU.

Parameters:
RESET_PC, 13'h0000, PC value loaded on reset.
MEM_TIMEOUT, 64, max consecutive cycles waiting for memDone before entering FAULT (legal range 1..255).

Ports:
clk  in  1  system clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
run  in  1  start/continue execution; sampled only in IDLE.
memDone  in  1  memory access complete; sampled only in FETCH, MEM_RD, MEM_WR.
opcode  in  3  decoded opcode from decoder; sampled only in DECODE.
BEQ  in  1  datapath equality result; sampled only in BRANCH.
newPC  in  13  branch target from datapath; sampled only in BRANCH.
read  out  1  memory read strobe.
write  out  1  memory write strobe.
instruction  out  1  1 = current memory access is an instruction fetch.
instructionType  out  1  1 = immediate format (ADDI, LW, SW, BEQ).
ALU_Op  out  3  ALU function select.
PC  out  13  program counter (registered).
irLoad  out  1  one-cycle pulse: latch fetched instruction.
regWrite  out  1  one-cycle pulse: write register file.
error  out  1  sticky; memory timeout occurred.
instr_count  out  16  retired-instruction counter.

Behaviour:
- All outputs except PC, error and instr_count decode from the state register and op_q only. No input-to-output combinational path.
- Opcode map (op_q latched in DECODE):
  - 000 ADD, 001 SUB, 010 AND, 011 OR: R-type.
  - 100 ADDI, 101 LW, 110 SW, 111 BEQ: instructionType=1.
- ALU_Op in EXECUTE/BRANCH:
  - ADD, ADDI, LW, SW: 000.
  - SUB, BEQ: 001.
  - AND: 010.
  - OR: 011.
  - All other states: 000.
- Reset (any state, mid-access included):
  - state=IDLE, PC=RESET_PC, op_q=000, wait counter=0, error=0, instr_count=0.
  - All strobes 0, ALU_Op=000.
- States and transitions:
  - IDLE: all strobes 0. run=1 -> FETCH; otherwise stay.
  - FETCH: read=1, instruction=1. memDone=1 -> DECODE, with irLoad=1 that same cycle (Moore exception: irLoad=read&memDone in FETCH). memDone=0 -> stay.
  - DECODE: latch op_q<=opcode; 1 cycle -> EXECUTE.
  - EXECUTE: ALU_Op/instructionType driven; 1 cycle. Next state by op_q:
    - R-type, ADDI -> WRITEBACK.
    - LW -> MEM_RD.
    - SW -> MEM_WR.
    - BEQ -> BRANCH.
  - MEM_RD: read=1, instruction=0, ALU_Op=000. memDone=1 -> WRITEBACK.
  - MEM_WR: write=1, instruction=0, ALU_Op=000. memDone=1 -> FETCH, with PC<=PC+1 and instr_count+1.
  - WRITEBACK: regWrite=1 for exactly 1 cycle -> FETCH, with PC<=PC+1 and instr_count+1.
  - BRANCH: ALU_Op=001, instructionType=1. PC<=BEQ ? newPC : PC+1; instr_count+1; -> FETCH.
  - FAULT: all strobes 0, error=1. Stays until reset; run ignored.
- Per-instruction latency with zero-wait memory (memDone high in first wait cycle):
  - ALU/ADDI, SW, BEQ: 4 cycles.
  - LW: 5 cycles.
- Timeout:
  - Wait counter clears on entry to FETCH, MEM_RD and MEM_WR.
  - Increments each wait-state cycle with memDone=0.
  - Reaching MEM_TIMEOUT with memDone still 0 -> FAULT, error<=1.
  - memDone=1 on the same cycle the count would reach the limit: completion wins.
- Arithmetic wrap-around:
  - PC+1 wraps 13'h1FFF -> 13'h0000.
  - instr_count wraps 16'hFFFF -> 0.
- Execution does not pause once started: run is not re-sampled after leaving IDLE.
- memDone asserted outside wait states is ignored.

Test Plan:
- Reset, run=1, memDone tied 1, opcode=000 -> states FETCH, DECODE, EXECUTE, WRITEBACK. Required: regWrite pulses on cycle 4; PC 0->1; instr_count=1; ALU_Op=000 in EXECUTE.
- opcode=101 (LW), memDone low 3 cycles in MEM_RD -> read=1, instruction=0 held 4 cycles in MEM_RD, then WRITEBACK. PC increments by 1; instructionType=1.
- opcode=111 (BEQ), BEQ=1, newPC=13'h0A5 -> ALU_Op=001 in EXECUTE/BRANCH; PC=13'h0A5 on next FETCH. Repeat with BEQ=0 -> PC=old+1.
- PC=13'h1FFF, opcode=110 (SW) -> write=1 in MEM_WR; after memDone, PC=13'h0000.
- MEM_TIMEOUT=4, memDone held 0 in FETCH -> FAULT after 4 wait cycles: error=1, read=0. Reset clears error, PC=RESET_PC, state IDLE.
- reset asserted mid-MEM_WR with write=1 -> next cycle write=0, state IDLE, instr_count=0, irLoad/regWrite never glitch.
